// File: rtl/rom_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rom_fetch_ctrl
// Description : Instruction-fetch sequencer for a 1-cycle synchronous program
//               ROM. Owns the PC, tags ROM data and buffers it in a 2-entry
//               FIFO handed to the CPU over valid/ready; jumps squash stale data.
//               Optional macro FETCH_BYPASS_EN presents a ROM response directly
//               when the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_fetch_ctrl #(
  parameter int              DATA      = 16,
  parameter int              ADDR      = 15,
  parameter logic [ADDR-1:0] BOOT_ADDR = '0
) (
  input  logic            a_clk,
  input  logic            reset,
  output logic [ADDR-1:0] rom_addr,
  input  logic [DATA-1:0] rom_q,
  input  logic            jmp,
  input  logic [ADDR-1:0] jmp_addr,
  output logic [DATA-1:0] instr,
  output logic [ADDR-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready
);

  localparam logic [ADDR-1:0] PC_ONE = ADDR'(1);

  logic [ADDR-1:0] fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [ADDR-1:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]      count_q, count_d;
  logic [DATA-1:0] data_q [0:1];
  logic [DATA-1:0] data_d [0:1];
  logic [ADDR-1:0] pc_q   [0:1];
  logic [ADDR-1:0] pc_d   [0:1];

  logic            deq;
  logic            bypass_hit;
  logic [1:0]      occ;
  logic [1:0]      cnt_pop;

  always_comb begin
    rom_addr = jmp ? jmp_addr : fetch_pc_q;

`ifdef FETCH_BYPASS_EN
    // A response arriving into an empty FIFO is shown in its own cycle,
    // unless a jump in this cycle squashes it.
    bypass_hit = inflight_q & ~jmp & ~reset & (count_q == 2'd0);
`else
    bypass_hit = 1'b0;
`endif

    instr_valid = (count_q != 2'd0) | bypass_hit;
    instr       = bypass_hit ? rom_q : data_q[0];
    instr_pc    = bypass_hit ? inflight_pc_q : pc_q[0];
    deq         = instr_valid & instr_ready;
    occ         = count_q + {1'b0, inflight_q} - {1'b0, deq};
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    data_d[0]     = data_q[0];
    data_d[1]     = data_q[1];
    pc_d[0]       = pc_q[0];
    pc_d[1]       = pc_q[1];
    cnt_pop       = count_q;

    // Head is entry 0; popping the last entry leaves its values visible.
    if (deq && (count_q != 2'd0)) begin
      cnt_pop = count_q - 2'd1;
      if (count_q == 2'd2) begin
        data_d[0] = data_q[1];
        pc_d[0]   = pc_q[1];
      end
    end
    count_d = cnt_pop;

    if (jmp) begin
      count_d       = 2'd0;
      inflight_d    = 1'b1;
      inflight_pc_d = jmp_addr;
      fetch_pc_d    = jmp_addr + PC_ONE;
    end else begin
      if (inflight_q) begin
        if (bypass_hit) begin
          data_d[0] = rom_q;
          pc_d[0]   = inflight_pc_q;
          count_d   = deq ? 2'd0 : 2'd1;
        end else begin
          data_d[cnt_pop[0]] = rom_q;
          pc_d[cnt_pop[0]]   = inflight_pc_q;
          count_d            = cnt_pop + 2'd1;
        end
      end

      if (occ < 2'd2) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + PC_ONE;
      end else begin
        inflight_d = 1'b0;
      end
    end
  end

  always_ff @(posedge a_clk) begin
    if (reset) begin
      fetch_pc_q    <= BOOT_ADDR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= 2'd0;
      data_q[0]     <= '0;
      data_q[1]     <= '0;
      pc_q[0]       <= '0;
      pc_q[1]       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      data_q[0]     <= data_d[0];
      data_q[1]     <= data_d[1];
      pc_q[0]       <= pc_d[0];
      pc_q[1]       <= pc_d[1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_fetch_ctrl.sv
`default_nettype none
// Directed bench for rom_fetch_ctrl: ROM[i] = i + 0x100, checks stream order,
// backpressure, jumps, wrap-around and mid-stream reset.
module tb_rom_fetch_ctrl;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam logic BYP = (LAT == 1);

  logic        a_clk;
  logic        reset;
  logic [14:0] rom_addr;
  logic [15:0] rom_q;
  logic        jmp;
  logic [14:0] jmp_addr;
  logic [15:0] instr;
  logic [14:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int checks   = 0;
  int failures = 0;

  rom_fetch_ctrl #(.DATA(16), .ADDR(15), .BOOT_ADDR(15'h0000)) u_dut (
    .a_clk       (a_clk),
    .reset       (reset),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .jmp         (jmp),
    .jmp_addr    (jmp_addr),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  always @(posedge a_clk) rom_q <= {1'b0, rom_addr} + 16'h0100;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [14:0] pc);
    logic [15:0] e;
    e = {1'b0, pc} + 16'h0100;
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_pc"},    {17'd0, instr_pc},    {17'd0, pc});
    chk({tag, "_instr"}, {16'd0, instr},       {16'd0, e});
  endtask

  task automatic cyc();
    @(posedge a_clk);
    @(negedge a_clk);
  endtask

  initial begin
    reset = 1'b1; jmp = 1'b0; jmp_addr = '0; instr_ready = 1'b1;
    repeat (3) cyc();
    #1;
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'd0);
    chk("rst_pc",    {17'd0, instr_pc}, 32'd0);

    // Boot stream
    cyc(); reset = 1'b0; #1;
    chk("boot_c0_valid", {31'd0, instr_valid}, 32'd0);
    cyc(); #1;
    chk("boot_c1_valid", {31'd0, instr_valid}, {31'd0, BYP});
    repeat (LAT-1) begin cyc(); #1; end
    chk_head("boot0", 15'd0);
    for (int i = 1; i < 4; i++) begin
      cyc();
      if (i == 3) instr_ready = 1'b0;
      #1;
      chk_head("seq", 15'(i));
    end

    // Backpressure
    for (int k = 0; k < 9; k++) begin
      cyc(); #1;
      chk_head("stall", 15'd3);
    end
    chk("frozen_pc", {17'd0, rom_addr}, 32'd5);
    cyc(); instr_ready = 1'b1; #1;
    chk_head("resume", 15'd3);
    for (int i = 4; i < 8; i++) begin
      cyc(); #1;
      chk_head("resume_seq", 15'(i));
    end

    // Jump with full FIFO
    cyc(); instr_ready = 1'b0; #1;
    chk_head("full8", 15'd8);
    cyc(); cyc();
    jmp = 1'b1; jmp_addr = 15'h0040; #1;
    chk_head("jmp_n", 15'd8);
    cyc(); jmp = 1'b0; instr_ready = 1'b1; #1;
    chk("jmp_n1_valid", {31'd0, instr_valid}, {31'd0, BYP});
    repeat (LAT-1) begin cyc(); #1; end
    chk_head("jmp_tgt", 15'h0040);
    cyc(); #1;
    chk_head("jmp_next", 15'h0041);

    // Back-to-back jumps
    cyc(); jmp = 1'b1; jmp_addr = 15'h0010; #1;
    cyc(); jmp_addr = 15'h0020; #1;
    chk("b2b_n1_valid", {31'd0, instr_valid}, 32'd0);
    cyc(); jmp = 1'b0; #1;
    chk("b2b_n2_valid", {31'd0, instr_valid}, {31'd0, BYP});
    repeat (LAT-1) begin cyc(); #1; end
    chk_head("b2b_tgt", 15'h0020);
    cyc(); #1;
    chk_head("b2b_next", 15'h0021);

    // Wrap-around
    cyc(); jmp = 1'b1; jmp_addr = 15'h7FFF; #1;
    cyc(); jmp = 1'b0; #1;
    chk("wrap_n1_valid", {31'd0, instr_valid}, {31'd0, BYP});
    repeat (LAT-1) begin cyc(); #1; end
    chk_head("wrap_top", 15'h7FFF);
    cyc(); #1;
    chk_head("wrap_zero", 15'h0000);
    cyc(); #1;
    chk_head("wrap_one", 15'h0001);

    // Reset mid-stream with buffered entries
    cyc(); instr_ready = 1'b0; #1;
    cyc(); cyc(); #1;
    chk("rm_full_valid", {31'd0, instr_valid}, 32'd1);
    cyc(); reset = 1'b1; #1;
    cyc(); reset = 1'b0; instr_ready = 1'b1; #1;
    chk("rm_valid", {31'd0, instr_valid}, 32'd0);
    chk("rm_instr", {16'd0, instr}, 32'd0);
    chk("rm_pc",    {17'd0, instr_pc}, 32'd0);
    cyc(); #1;
    chk("rm_c1_valid", {31'd0, instr_valid}, {31'd0, BYP});
    repeat (LAT-1) begin cyc(); #1; end
    chk_head("rm_boot", 15'd0);
    cyc(); #1;
    chk_head("rm_seq", 15'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
